// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM state
// encodings and the smallest divisor the divider can produce.
package clk_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Smallest legal divisor; anything below is rejected on load.
   localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_phase_cnt.sv
// Phase counter for the programmable clock divider.
// Counts 0 .. N-1 while advancing, flags the last cycle of a period
// (wrap) and tells the top whether the next cycle is still in the
// high phase, whose length is ceil(N/2).
module clk_div_phase_cnt
   import clk_div_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             advance_i,
   input  logic [DIV_W-1:0] div_n_i,
   output logic             wrap_o,
   output logic             high_next_o
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic [DIV_W:0]   cnt_inc;
   logic [DIV_W:0]   high_len;

   // Wrap on the last cycle of the period; the high phase covers counts
   // 0 .. H-1 with H = N - floor(N/2), computed one bit wider so the
   // compare never overflows.
   always_comb begin
      wrap_o      = (cnt_q == (div_n_i - DIV_W'(1)));
      cnt_inc     = {1'b0, cnt_q} + (DIV_W + 1)'(1);
      high_len    = {1'b0, div_n_i} - ({1'b0, div_n_i} >> 1);
      high_next_o = (cnt_inc < high_len);
   end

   // Next count: hold at zero while cleared, otherwise step and wrap at N-1.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (advance_i) begin
         if (wrap_o) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: registered clk_out with period N
// clk cycles (high ceil(N/2), low floor(N/2)). Divisor changes and
// enable/disable only take effect at period boundaries, so clk_out never
// glitches except when rst truncates a period.
// Optional feature: define CLK_DIV_TICK_EN to add the 'tick' output, a
// one-cycle pulse in every cycle where clk_out has just risen.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_val,
   output logic             div_ack,
   output logic             div_err,
   output logic [DIV_W-1:0] div_active,
   output logic             running,
   output logic             clk_out
`ifdef CLK_DIV_TICK_EN
   ,
   output logic             tick
`endif
);

   state_t           state_q;
   state_t           state_d;
   logic             clk_out_q;
   logic             clk_out_d;
   logic [DIV_W-1:0] div_active_q;
   logic [DIV_W-1:0] div_active_d;
   logic [DIV_W-1:0] div_pend_q;
   logic [DIV_W-1:0] div_pend_d;
   logic             pend_q;
   logic             pend_d;
   logic             ack_q;
   logic             ack_d;
   logic             err_q;
   logic             err_d;

   logic             load_ok;
   logic             load_bad;
   logic             wrap;
   logic             high_next;
   logic             cnt_clear;
   logic             cnt_advance;

   // The counter sits at zero while idle and free-runs otherwise.
   always_comb begin
      cnt_clear   = (state_q == ST_IDLE);
      cnt_advance = (state_q != ST_IDLE);
   end

   clk_div_phase_cnt #(
      .DIV_W (DIV_W)
   ) u_phase_cnt (
      .clk_i       (clk),
      .rst_ni      (rst),
      .clear_i     (cnt_clear),
      .advance_i   (cnt_advance),
      .div_n_i     (div_active_q),
      .wrap_o      (wrap),
      .high_next_o (high_next)
   );

   // Next-state logic: FSM, clk_out shaping, divisor load/pending handling
   // and the ack/err pulses. A load that lands on a wrap edge goes pending
   // for the following wrap, while an older pending value is applied on
   // that same edge.
   always_comb begin
      state_d      = state_q;
      clk_out_d    = clk_out_q;
      div_active_d = div_active_q;
      div_pend_d   = div_pend_q;
      pend_d       = pend_q;

      load_ok  = div_load && (div_val >= DIV_W'(MIN_DIV));
      load_bad = div_load && !load_ok;
      ack_d    = load_ok;
      err_d    = load_bad;

      case (state_q)
         ST_IDLE: begin
            clk_out_d = 1'b0;
            if (en) begin
               state_d   = ST_RUN;
               clk_out_d = 1'b1;
            end
            if (load_ok) begin
               div_active_d = div_val;
            end
         end

         ST_RUN, ST_DRAIN: begin
            if (wrap) begin
               state_d   = en ? ST_RUN : ST_IDLE;
               clk_out_d = en;
               if (pend_q) begin
                  div_active_d = div_pend_q;
                  pend_d       = 1'b0;
               end
            end else begin
               state_d   = en ? ST_RUN : ST_DRAIN;
               clk_out_d = high_next;
            end
            if (load_ok) begin
               div_pend_d = div_val;
               pend_d     = 1'b1;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            clk_out_d = 1'b0;
            pend_d    = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         clk_out_q    <= 1'b0;
         div_active_q <= DIV_W'(DEFAULT_DIV);
         div_pend_q   <= '0;
         pend_q       <= 1'b0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         clk_out_q    <= clk_out_d;
         div_active_q <= div_active_d;
         div_pend_q   <= div_pend_d;
         pend_q       <= pend_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      clk_out    = clk_out_q;
      div_active = div_active_q;
      div_ack    = ack_q;
      div_err    = err_q;
      running    = (state_q != ST_IDLE);
   end

`ifdef CLK_DIV_TICK_EN
   logic tick_q;

   // Tick is registered alongside clk_out and is high exactly when clk_out just rose.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= clk_out_d & ~clk_out_q;
      end
   end

   assign tick = tick_q;
`else
   // Without the tick option there is no extra logic.
`endif

endmodule
